// File: rtl/rvm_uart_tx_seq_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encodings,
// bit-counter width and the default baud divisor (176 x 20ns = 3520ns per bit).
package rvm_uart_tx_seq_pkg;

  localparam int RVM_UART_CLKS_PER_BIT = 176;

  // Wide enough for DATA_BITS (<=9), STOP_BITS (<=2) and GAP_BITS (<=15).
  localparam int UTX_BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    RVM_UTX_IDLE   = 3'd0,
    RVM_UTX_START  = 3'd1,
    RVM_UTX_DATA   = 3'd2,
    RVM_UTX_PARITY = 3'd3,
    RVM_UTX_STOP   = 3'd4,
    RVM_UTX_GAP    = 3'd5
  } utx_state_e;

endpackage

// File: rtl/rvm_sync_fifo.sv
// Generic synchronous FIFO, registered count, pop data read combinationally from the head.
// Latency: a pushed word is visible at the head one edge later.
// Backpressure: push is ignored while full, pop is ignored while empty.
module rvm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/rvm_uart_tx_seq.sv
// Buffered UART transmitter: start, DATA_BITS LSB first, parity when RVM_UART_TX_PARITY_EN, stop, gap.
// Latency: word accepted into an empty FIFO while idle -> start bit driven on the next edge; frames run back to back.
// Backpressure: in_ready drops while the FIFO is full; enable=0 lets the current frame finish, then holds.
module rvm_uart_tx_seq
  import rvm_uart_tx_seq_pkg::*;
#(
  parameter int CLKS_PER_BIT = RVM_UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        in_valid,
  input  logic [DATA_BITS-1:0]        in_data,
  output logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        uart_txd
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]        BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [UTX_BIT_CNT_W-1:0] DATA_LAST = UTX_BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [UTX_BIT_CNT_W-1:0] STOP_LAST = UTX_BIT_CNT_W'(STOP_BITS - 1);
  localparam logic [UTX_BIT_CNT_W-1:0] GAP_LAST  = UTX_BIT_CNT_W'(GAP_BITS - 1);
  localparam bit                       HAS_GAP   = (GAP_BITS != 0);

  utx_state_e                 state_q, state_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [UTX_BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]       shift_q, shift_d;
  logic                       txd_q, txd_d;
  logic                       bit_end, frame_end, launch, can_start;
  logic                       fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]       fifo_dat;

`ifdef RVM_UART_TX_PARITY_EN
  logic parity_q, parity_d;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  rvm_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (launch),
    .pop_data  (fifo_dat),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign can_start = enable & ~fifo_empty;
  assign bit_end   = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    frame_end = 1'b0;
    launch    = 1'b0;

    if (state_q != RVM_UTX_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      RVM_UTX_IDLE: launch = can_start;
      RVM_UTX_START: begin
        if (bit_end) begin
          state_d = RVM_UTX_DATA;
          bit_d   = '0;
        end
      end
      RVM_UTX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef RVM_UART_TX_PARITY_EN
            state_d = RVM_UTX_PARITY;
`else
            state_d = RVM_UTX_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef RVM_UART_TX_PARITY_EN
      RVM_UTX_PARITY: begin
        if (bit_end) begin
          state_d = RVM_UTX_STOP;
          bit_d   = '0;
        end
      end
`endif
      RVM_UTX_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (HAS_GAP) state_d = RVM_UTX_GAP;
            else         frame_end = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RVM_UTX_GAP: begin
        if (bit_end) begin
          if (bit_q == GAP_LAST) frame_end = 1'b1;
          else                   bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = RVM_UTX_IDLE;
    endcase

    // The last cycle of a frame may chain straight into the next start bit.
    if (frame_end) begin
      state_d = RVM_UTX_IDLE;
      bit_d   = '0;
      launch  = can_start;
    end

    if (launch) begin
      state_d = RVM_UTX_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = fifo_dat;
    end
  end

`ifdef RVM_UART_TX_PARITY_EN
  assign parity_d = launch ? ((^fifo_dat) ^ (PARITY_ODD != 0)) : parity_q;
`endif

  // Line level is decoded from the next state so uart_txd is a clean register output.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      RVM_UTX_START:  txd_d = 1'b0;
      RVM_UTX_DATA:   txd_d = shift_d[0];
`ifdef RVM_UART_TX_PARITY_EN
      RVM_UTX_PARITY: txd_d = parity_d;
`endif
      default:        txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= RVM_UTX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef RVM_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef RVM_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign in_ready   = ~fifo_full;
  assign busy       = (state_q != RVM_UTX_IDLE);
  assign frame_done = frame_end;
  assign uart_txd   = txd_q;

endmodule

// File: tb/tb_rvm_uart_tx_seq.sv
// Directed bench for rvm_uart_tx_seq: frame-level reference model, per-cycle compare, mid-bit UART monitor.
`timescale 1ns/1ps
module tb_rvm_uart_tx_seq;
  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int SB    = 1;
  localparam int GB    = 0;
  localparam int DEPTH = 8;
  localparam int ODD   = 0;
`ifdef RVM_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DW + P + SB + GB;
  localparam int FLEN  = NBITS * CPB;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, busy, frame_done, uart_txd;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;

  rvm_uart_tx_seq #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DW),
    .STOP_BITS    (SB),
    .GAP_BITS     (GB),
    .FIFO_DEPTH   (DEPTH),
    .PARITY_ODD   (ODD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_done (frame_done),
    .uart_txd   (uart_txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of waiting words plus the frame in flight as (word, cycle index).
  logic [7:0] m_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] m_word = 8'h00;
  bit         m_act = 1'b0;
  int         m_cyc = 0;
  int         pre_sz;
  bit         m_launch;
  int         rst_epoch = 0;
  logic       mon_par = 1'b0;

  function automatic logic exp_bit(input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    if (P == 1 && idx == DW + 1) return (^w) ^ (ODD != 0);
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_q.delete();
        sent_q.delete();
        m_act = 1'b0;
        m_cyc = 0;
        rst_epoch++;
      end else begin
        pre_sz   = m_q.size();
        m_launch = 1'b0;
        if (m_act) begin
          if (m_cyc == FLEN - 1) begin
            m_act    = 1'b0;
            m_launch = (pre_sz != 0) && enable;
          end else begin
            m_cyc = m_cyc + 1;
          end
        end else begin
          m_launch = (pre_sz != 0) && enable;
        end
        if (m_launch) begin
          m_word = m_q.pop_front();
          m_act  = 1'b1;
          m_cyc  = 0;
        end
        if (in_valid && pre_sz < DEPTH) begin
          m_q.push_back(in_data);
          sent_q.push_back(in_data);
        end
      end
    end
  end

  // Every cycle: all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("txd",        uart_txd,   m_act ? exp_bit(m_word, m_cyc / CPB) : 1'b1);
      chk("busy",       busy,       m_act);
      chk("frame_done", frame_done, m_act && (m_cyc == FLEN - 1));
      chk("fifo_count", fifo_count, m_q.size());
      chk("in_ready",   in_ready,   m_q.size() < DEPTH);
    end
  end

  // Mid-bit UART monitor; frames cut short by reset are dropped.
  initial begin
    int ep;
    logic [7:0] b;
    logic pb, sb;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && uart_txd === 1'b0) begin
        ep = rst_epoch;
        b  = 8'h00;
        repeat (CPB + CPB/2 - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
          b[i] = uart_txd;
          if (i < DW - 1) repeat (CPB) @(negedge clk);
        end
        pb = 1'b1;
`ifdef RVM_UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        pb = uart_txd;
`endif
        repeat (CPB) @(negedge clk);
        sb = uart_txd;
        if (ep == rst_epoch) begin
          mon_par = pb;
          rx_log.push_back(b);
          chk("rx_stop", sb, 1'b1);
          if (sent_q.size() == 0) fail("rx_unexpected", int'(b), -1);
          else chk("rx_data", b, sent_q.pop_front());
`ifdef RVM_UART_TX_PARITY_EN
          chk("rx_parity", pb, (^b) ^ (ODD != 0));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] d, output int waited);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (m_q.size() >= DEPTH && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 500) fail("push_wait", n, 0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    waited = n;
  endtask

  task automatic measure(output int bcyc, output int fd, output int peak);
    bit seen;
    seen = 1'b0;
    bcyc = 0; fd = 0; peak = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (busy) begin
        seen = 1'b1;
        bcyc++;
        if (frame_done) fd++;
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy == 1'b0 && fifo_count == 4'd0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail("idle_wait", n, 0);
    repeat (4) @(negedge clk);
    #2;
  endtask

  int w, bc, fd, pk;
  logic [7:0] t2_vals [4];

  initial begin
    t2_vals[0] = 8'hAB; t2_vals[1] = 8'hCD; t2_vals[2] = 8'hEF; t2_vals[3] = 8'hAB;
    repeat (3) @(posedge clk); #2;
    chk("rst_txd",        uart_txd,   1'b1);
    chk("rst_in_ready",   in_ready,   1'b1);
    chk("rst_fifo_count", fifo_count, 4'd0);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    resetn = 1'b1;
    repeat (2) @(posedge clk); #2;

    // 1: single word 8'h30
    rx_log.delete();
    fork
      begin
        push(8'h30, w);
        chk("t1_txd_at_accept", uart_txd, 1'b1);
        @(posedge clk); #1;
        chk("t1_txd_fall", uart_txd, 1'b0);
      end
      measure(bc, fd, pk);
    join
    wait_idle();
    chk("t1_frame_len", bc, 32'd40 + 4 * P);
    chk("t1_done_pulses", fd, 1);
    chk("t1_rx_count", rx_log.size(), 1);
    if (rx_log.size() >= 1) chk("t1_rx_byte", rx_log[0], 8'h30);

    // 2: four words back to back
    rx_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) push(t2_vals[i], w);
      end
      measure(bc, fd, pk);
    join
    wait_idle();
    chk("t2_busy_cycles", bc, 4 * (40 + 4 * P));
    chk("t2_done_pulses", fd, 4);
    chk("t2_peak_count", pk, 3);
    chk("t2_rx_count", rx_log.size(), 4);
    for (int i = 0; i < 4 && i < rx_log.size(); i++) chk("t2_rx_byte", rx_log[i], t2_vals[i]);

    // 3: fill the FIFO behind a frame in flight, ninth word stalls until a pop
    rx_log.delete();
    push(8'h11, w);
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), w);
    chk("t3_full_fifo_count", fifo_count, 4'd8);
    chk("t3_in_ready_low", in_ready, 1'b0);
    push(8'h28, w);
    chk("t3_stall_edges", w, 33 + 4 * P);
    wait_idle();
    chk("t3_rx_count", rx_log.size(), 10);
    if (rx_log.size() == 10) begin
      chk("t3_rx_first", rx_log[0], 8'h11);
      for (int i = 1; i < 10; i++) chk("t3_rx_order", rx_log[i], 8'h20 + 8'(i - 1));
    end

    // 4: reset in the middle of data bit 3 of 8'hFF
    rx_log.delete();
    push(8'hFF, w);
    push(8'h12, w);
    repeat (17) @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("t4_txd", uart_txd, 1'b1);
    chk("t4_fifo_count", fifo_count, 4'd0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_frame_done", frame_done, 1'b0);
    repeat (2) @(posedge clk); #2;
    resetn = 1'b1;
    fd = 0;
    repeat (60) begin
      @(negedge clk);
      if (frame_done) fd++;
    end
    chk("t4_no_frame_done", fd, 0);
    chk("t4_no_rx", rx_log.size(), 0);
    #2;

    // 5: enable dropped during the stop bit with two words queued
    rx_log.delete();
    push(8'h5A, w);
    push(8'h3C, w);
    push(8'hC3, w);
    repeat (36 + 4 * P) @(posedge clk); #2;
    enable = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("t5_txd_held", uart_txd, 1'b1);
    chk("t5_fifo_count", fifo_count, 4'd2);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rx_first", rx_log.size(), 1);
    #1;
    enable = 1'b1;
    @(posedge clk); #1;
    chk("t5_restart_busy", busy, 1'b1);
    chk("t5_restart_txd", uart_txd, 1'b0);
    chk("t5_restart_count", fifo_count, 4'd1);
    wait_idle();
    chk("t5_rx_count", rx_log.size(), 3);

    // 6: 8'h07, frame length and parity bit depend on the build
    rx_log.delete();
    fork
      push(8'h07, w);
      measure(bc, fd, pk);
    join
    wait_idle();
`ifdef RVM_UART_TX_PARITY_EN
    chk("t6_frame_len", bc, 44);
    chk("t6_parity_bit", mon_par, 1'b1);
`else
    chk("t6_frame_len", bc, 40);
`endif
    chk("t6_rx_count", rx_log.size(), 1);
    if (rx_log.size() >= 1) chk("t6_rx_byte", rx_log[0], 8'h07);

    chk("all_sent_received", sent_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
